fpcvt_pipe: RTL and testbench
=============================

FPCVT_PIPE -- requirements
Module: fpcvt_pipe

Interface
REQ-001 Parameter W, default 12: input two's-complement width (>= 4).
REQ-002 Parameter EXP_W, default 3: exponent field width.
REQ-003 Parameter MAN_W, default 4: significand field width; legal only if W-1-MAN_W <= 2^EXP_W-1 (elaboration error otherwise).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  input word present.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 d  input  W  two's-complement sample.
REQ-009 rnd_en  input  1  1 = round-half-up on magnitude, 0 = truncate; sampled with d.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 s  output  1  sign.
REQ-013 e  output  EXP_W  exponent.
REQ-014 f  output  MAN_W  significand; represented value = (-1)^s * f * 2^e.

Function
REQ-015 Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
REQ-016 Three-stage pipeline, latency exactly 3 cycles from accept to out_valid with no stalls; throughput 1/cycle.
REQ-017 Global advance enable adv = out_ready || !out_valid; in_ready = adv; when adv=0 all stage registers hold (no loss, no duplication).
REQ-018 Empty stages propagate valid=0 bubbles; out_valid never asserts without a prior accept.
REQ-019 Stage 1: s = d[W-1]; mag = d[W-2:0] if s=0, else two's-complement negation of d[W-2:0]; d = 1 followed by W-1 zeros saturates mag to all ones (W-1 bits).
REQ-020 Stage 2: p = index of most-significant 1 in mag; if mag < 2^MAN_W then e=0, f=mag[MAN_W-1:0], round bit=0; else e=p-MAN_W+1, f=mag[p:p-MAN_W+1], round bit=mag[p-MAN_W].
REQ-021 Stage 3: if rnd_en && round bit, f=f+1; on significand overflow (f wraps to 0) set f = 1 followed by MAN_W-1 zeros and e=e+1.
REQ-022 If e after rounding exceeds 2^EXP_W-1, saturate: e = all ones, f = all ones.
REQ-023 Zero input yields s=0, e=0, f=0; no negative zero produced.
REQ-024 rnd_en travels with its data word; changing rnd_en mid-stream affects only subsequently accepted words.
REQ-025 s, e, f hold stable while out_valid && !out_ready.

Reset
REQ-026 While rst_n=0 at a clock edge, all stage valids clear and s, e, f clear to 0; out_valid=0 next cycle.
REQ-027 Reset mid-operation discards all in-flight words; none appear after reset release.
REQ-028 in_ready is 1 in the first cycle after reset release (pipeline empty).

Structure
REQ-029 Package fpcvt_pkg holds default W/EXP_W/MAN_W constants and the per-stage payload record widths.
REQ-030 Leading-one detection is one sub-module, fpcvt_lod: input W-1 bits, outputs p and zero flag, purely combinational, parametrised on width.
REQ-031 Datapath is stage registers plus fpcvt_lod; no other sub-modules.

Verification (default parameters)
REQ-032 d=12'd422, rnd_en=0 -> after 3 cycles s=0, e=5, f=4'b1101 (416).
REQ-033 d=12'd125, rnd_en=1 -> rounding overflow: s=0, e=4, f=4'b1000 (128); same with rnd_en=0 -> e=3, f=4'b1111.
REQ-034 d=12'h800 with rnd_en=1 -> s=1, e=7, f=4'b1111 (saturated); d=12'hFFB (-5) -> s=1, e=0, f=4'b0101.
REQ-035 Stream 0,1,2,...,20 back-to-back with out_ready toggled pseudo-randomly -> every result appears exactly once, in order, matching a scoreboard model; outputs stable during stalls.
REQ-036 Accept 3 words, assert rst_n=0 for one cycle with data in flight -> out_valid=0 after reset, no stale results, in_ready=1 next cycle.

Source files
------------

// File: rtl/fpcvt_pkg.sv
// Shared constants for the integer-to-small-float conversion pipeline.
package fpcvt_pkg;

    // Default geometry: 12-bit two's-complement in, 3-bit exponent, 4-bit significand out.
    localparam int W_DEF     = 12;
    localparam int EXP_W_DEF = 3;
    localparam int MAN_W_DEF = 4;

    // Stage 1 payload: sign, magnitude (w-1 bits), rounding request.
    function automatic int s1_pay_w(input int w);
        return 1 + (w - 1) + 1;
    endfunction

    // Stage 2 payload: sign, exponent, truncated significand, round bit, rounding request.
    function automatic int s2_pay_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w + 1 + 1;
    endfunction

    // Stage 3 payload: the final sign/exponent/significand triple.
    function automatic int s3_pay_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

endpackage

// File: rtl/fpcvt_lod.sv
// Leading-one detector: position of the most-significant set bit plus an all-zero flag.
module fpcvt_lod #(
    parameter int N  = 11,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  v,
    output logic [PW-1:0] p,
    output logic          zero
);

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        p    = '0;
        zero = ~|v;
        for (int i = 0; i < N; i++) begin
            if (v[i]) p = PW'(i);
        end
    end

endmodule

// File: rtl/fpcvt_pipe.sv
// Three-stage two's-complement to sign/exponent/significand converter with
// a single global advance enable (the whole pipe stalls together).
module fpcvt_pipe
    import fpcvt_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     d,
    input  logic             rnd_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             s,
    output logic [EXP_W-1:0] e,
    output logic [MAN_W-1:0] f
);

    localparam int N  = W - 1;
    localparam int PW = $clog2(N);

    // The largest exponent the magnitude can need must fit the exponent field.
    if (W < 4 || EXP_W < 1 || MAN_W < 1 || MAN_W > N || (N - MAN_W) > (2**EXP_W - 1)) begin : g_bad_params
        $error("fpcvt_pipe: illegal W/EXP_W/MAN_W combination");
    end

    logic adv;
    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    // ---------------- stage 1: sign and magnitude ----------------
    logic [N-1:0] low, mag_c;
    logic         v1, s1, r1;
    logic [N-1:0] mag1;

    // Negative inputs are negated in N bits; the most-negative code has no
    // positive twin, so it clamps to the largest magnitude.
    always_comb begin
        low   = d[N-1:0];
        mag_c = low;
        if (d[W-1]) mag_c = (low == '0) ? '1 : (~low) + N'(1);
    end

    // Stage 1 register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0; s1 <= 1'b0; r1 <= 1'b0; mag1 <= '0;
        end else if (adv) begin
            v1 <= in_valid; s1 <= d[W-1]; r1 <= rnd_en; mag1 <= mag_c;
        end
    end

    // ---------------- stage 2: normalise ----------------
    logic [PW-1:0]    p, sh;
    logic             zero, big, rb_c;
    logic [N:0]       wide;
    logic [EXP_W-1:0] e_c;
    logic [MAN_W-1:0] f_c;
    logic             v2, s2, r2, rb2;
    logic [EXP_W-1:0] e2;
    logic [MAN_W-1:0] f2;

    fpcvt_lod #(.N(N), .PW(PW)) u_lod (
        .v    (mag1),
        .p    (p),
        .zero (zero)
    );

    // Shift the window so the leading one lands at the significand MSB; the
    // extra zero appended below the LSB makes the round bit fall out as wide[0].
    always_comb begin
        big  = !zero && (p >= PW'(MAN_W));
        sh   = p - PW'(MAN_W - 1);
        wide = {mag1, 1'b0} >> sh;
        e_c  = big ? EXP_W'(sh) : '0;
        f_c  = big ? wide[MAN_W:1] : mag1[MAN_W-1:0];
        rb_c = big && wide[0];
    end

    // Stage 2 register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2 <= 1'b0; s2 <= 1'b0; r2 <= 1'b0; rb2 <= 1'b0; e2 <= '0; f2 <= '0;
        end else if (adv) begin
            v2 <= v1; s2 <= s1; r2 <= r1; rb2 <= rb_c; e2 <= e_c; f2 <= f_c;
        end
    end

    // ---------------- stage 3: round and saturate ----------------
    logic [MAN_W:0]   fs;
    logic [EXP_W:0]   es;
    logic [MAN_W-1:0] f_r, f_o;
    logic [EXP_W-1:0] e_o;
    logic             v3;

    // A carry out of the significand renormalises to 100..0 with exponent+1;
    // a carry out of the exponent clamps the whole result to all ones.
    always_comb begin
        fs  = {1'b0, f2} + (MAN_W+1)'(r2 && rb2);
        es  = {1'b0, e2} + (EXP_W+1)'(fs[MAN_W]);
        f_r = fs[MAN_W] ? (MAN_W'(1) << (MAN_W - 1)) : fs[MAN_W-1:0];
        e_o = es[EXP_W] ? '1 : es[EXP_W-1:0];
        f_o = es[EXP_W] ? '1 : f_r;
    end

    // Output register; holds while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3 <= 1'b0; s <= 1'b0; e <= '0; f <= '0;
        end else if (adv) begin
            v3 <= v2; s <= s2; e <= e_o; f <= f_o;
        end
    end

    assign out_valid = v3;

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Bench for fpcvt_pipe: directed corner values, latency, random stalled
// stream against a scoreboard, and mid-flight reset.
module tb_fpcvt_pipe;

    localparam int W     = 12;
    localparam int EXP_W = 3;
    localparam int MAN_W = 4;
    localparam int RW    = 1 + EXP_W + MAN_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     d = '0;
    logic             rnd_en = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] sb[$];
    logic [RW-1:0] held;
    logic [RW-1:0] ex;
    logic          held_vld = 1'b0;

    fpcvt_pipe #(.W(W), .EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .rnd_en    (rnd_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .e         (e),
        .f         (f)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: value-level conversion. Halve the magnitude until it fits
    // the significand, remembering the last bit shifted out.
    function automatic logic [RW-1:0] model(input logic [W-1:0] dv, input logic r);
        int v, sg, m, ee, ff, rb;
        v  = int'($signed(dv));
        sg = (v < 0) ? 1 : 0;
        m  = (v < 0) ? -v : v;
        if (m > 2**(W-1) - 1) m = 2**(W-1) - 1;
        ee = 0; ff = m; rb = 0;
        while (ff >= 2**MAN_W) begin
            rb = ff % 2;
            ff = ff / 2;
            ee++;
        end
        if (r && rb == 1) ff++;
        if (ff == 2**MAN_W) begin
            ff = ff / 2;
            ee++;
        end
        if (ee > 2**EXP_W - 1) begin
            ee = 2**EXP_W - 1;
            ff = 2**MAN_W - 1;
        end
        return {sg[0], EXP_W'(ee), MAN_W'(ff)};
    endfunction

    // Monitor: scoreboard on both handshakes and hold-stability during stalls.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("spurious_out", 1, 0);
            else begin
                ex = sb.pop_front();
                chk("stream_sef", {s, e, f}, ex);
            end
        end
        if (held_vld) chk("hold_sef", {out_valid, s, e, f}, {1'b1, held});
        held_vld = rst_n && out_valid && !out_ready;
        held     = {s, e, f};
        if (rst_n && in_valid && in_ready) sb.push_back(model(d, rnd_en));
        if (!rst_n) sb.delete();
    end

    // Present one word from posedge+1 and return at posedge+1 after it is taken.
    task automatic send(input logic [W-1:0] dv, input logic r, input bit rr);
        int n;
        n = 0;
        d = dv; rnd_en = r; in_valid = 1'b1;
        if (rr) out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            if (rr) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Directed vectors: d, rnd_en, expected s, e, f
    typedef struct { logic [W-1:0] dv; logic r; logic es; logic [EXP_W-1:0] ee; logic [MAN_W-1:0] ef; } vec_t;
    vec_t vecs[7] = '{
        '{12'd422, 1'b0, 1'b0, 3'd5, 4'b1101},
        '{12'd125, 1'b1, 1'b0, 3'd4, 4'b1000},
        '{12'd125, 1'b0, 1'b0, 3'd3, 4'b1111},
        '{12'h800, 1'b1, 1'b1, 3'd7, 4'b1111},
        '{12'hFFB, 1'b0, 1'b1, 3'd0, 4'b0101},
        '{12'hFFB, 1'b1, 1'b1, 3'd0, 4'b0101},
        '{12'd0,   1'b1, 1'b0, 3'd0, 4'b0000}
    };

    initial begin
        int n;
        logic [W-1:0] rv;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sef", {s, e, f}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // directed values with latency
        foreach (vecs[i]) begin
            out_ready = 1'b1;
            send(vecs[i].dv, vecs[i].r, 1'b0);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid && n < 10);
            chk($sformatf("lat_%0d", i), n, 3);
            chk($sformatf("dir_%0d", i), {s, e, f}, {vecs[i].es, vecs[i].ee, vecs[i].ef});
            @(posedge clk); #1;
        end

        // 0..20 back-to-back then random words, with random backpressure
        for (int i = 0; i <= 20; i++) send(W'(i), 1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: rv = 12'h800;
                1: rv = 12'h7FF;
                2: rv = W'($urandom_range(0, 40)) - W'(20);
                default: rv = W'($urandom);
            endcase
            send(rv, 1'($urandom_range(0, 1)), 1'b1);
        end
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", sb.size(), 0);
        out_ready = 1'b1;

        // reset with three words in flight
        repeat (3) @(posedge clk); #1;
        send(12'd300, 1'b1, 1'b0);
        send(12'hF00, 1'b0, 1'b0);
        send(12'd77,  1'b1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_stale", out_valid, 0);
        end

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
